// File: rtl/gamepad_pmod_pkg.sv
// Shared constants and width helpers for the multi-controller Gamepad Pmod receiver.
package gamepad_pmod_pkg;

   localparam int DEF_NUM_CTRL      = 2;
   localparam int DEF_BITS_PER_CTRL = 12;
   localparam int FRAME_BITS        = DEF_NUM_CTRL * DEF_BITS_PER_CTRL;
   localparam int CNT_W             = $clog2(FRAME_BITS + 2);
   localparam logic [FRAME_BITS-1:0] FRAME_ONES = '1;

   // Bit counter must hold 0 .. frame_bits+1 (the saturation value).
   function automatic int cnt_width(input int frame_bits);
      return $clog2(frame_bits + 2);
   endfunction

   function automatic int wd_width(input int timeout);
      return (timeout < 2) ? 1 : $clog2(timeout + 1);
   endfunction

endpackage

// File: rtl/gamepad_pmod_rx_multi_sync.sv
// Multi-stage synchroniser for one async Pmod pin, with a rising-edge pulse on the synced level.
module pmod_pin_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout,
   output logic rise
);

   logic [STAGES-1:0] chain_q, chain_d;
   logic              prev_q, prev_d;

   always_comb begin
      chain_d = {chain_q[STAGES-2:0], din};
      prev_d  = chain_q[STAGES-1];
   end

   // Reset to ones so a pin idling high after reset never looks like a fresh edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         chain_q <= '1;
         prev_q  <= 1'b1;
      end else begin
         chain_q <= chain_d;
         prev_q  <= prev_d;
      end
   end

   assign dout = chain_q[STAGES-1];
   assign rise = chain_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/gamepad_pmod_rx_multi.sv
// Gamepad Pmod serial receiver for NUM_CTRL controllers: frame validation, presence,
// sticky press/release events with write-one-to-clear, and a link watchdog.
module gamepad_pmod_rx_multi
   import gamepad_pmod_pkg::*;
#(
   parameter int NUM_CTRL       = DEF_NUM_CTRL,
   parameter int BITS_PER_CTRL  = DEF_BITS_PER_CTRL,
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 0
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                en,
   input  logic                                pmod_data,
   input  logic                                pmod_clk,
   input  logic                                pmod_latch,
   output logic [NUM_CTRL*BITS_PER_CTRL-1:0]   data_out,
   output logic [NUM_CTRL-1:0]                 present,
   output logic                                frame_valid,
   output logic                                frame_error,
   output logic                                stale,
   output logic [NUM_CTRL*BITS_PER_CTRL-1:0]   pressed,
   output logic [NUM_CTRL*BITS_PER_CTRL-1:0]   released,
   input  logic [NUM_CTRL*BITS_PER_CTRL-1:0]   evt_clr,
   output logic                                irq
);

   localparam int FB = NUM_CTRL * BITS_PER_CTRL;
   localparam int CW = cnt_width(FB);
   localparam int WW = wd_width(TIMEOUT_CYCLES);
   localparam logic [FB-1:0]            ONES     = '1;
   localparam logic [BITS_PER_CTRL-1:0] CTRL_ONES = '1;
   localparam logic [CW-1:0]            CNT_MAX  = CW'(FB + 1);
   localparam logic [WW-1:0]            WD_MAX   = WW'(TIMEOUT_CYCLES);

   logic data_sync, clk_rise, latch_rise, unused_clk_lvl, unused_latch_lvl;

   pmod_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_data (
      .clk(clk), .rst(rst), .din(pmod_data), .dout(data_sync), .rise());
   pmod_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_clk (
      .clk(clk), .rst(rst), .din(pmod_clk), .dout(unused_clk_lvl), .rise(clk_rise));
   pmod_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_latch (
      .clk(clk), .rst(rst), .din(pmod_latch), .dout(unused_latch_lvl), .rise(latch_rise));

   logic [FB-1:0] shift_q, shift_d, shift_in, data_q, data_d;
   logic [FB-1:0] pressed_q, pressed_d, released_q, released_d, set_p, set_r;
   logic [CW-1:0] cnt_q, cnt_d, cnt_in;
   logic [WW-1:0] wd_q, wd_d, wd_inc;
   logic          stale_q, stale_d, fv_q, fv_d, fe_q, fe_d, commit_ok;
   logic [BITS_PER_CTRL-1:0] old_f, new_f;

   always_comb begin
      shift_d   = shift_q;
      cnt_d     = cnt_q;
      data_d    = data_q;
      wd_d      = wd_q;
      stale_d   = stale_q;
      fv_d      = 1'b0;
      fe_d      = 1'b0;
      commit_ok = 1'b0;
      shift_in  = shift_q;
      cnt_in    = cnt_q;
      wd_inc    = wd_q + 1'b1;
      if (!en) begin
         shift_d = ONES;
         cnt_d   = '0;
      end else begin
         // A clk edge in the same cycle as the latch is folded in before the commit.
         if (clk_rise) begin
            shift_in = {shift_q[FB-2:0], data_sync};
            if (cnt_q != CNT_MAX) cnt_in = cnt_q + 1'b1;
         end
         shift_d = shift_in;
         cnt_d   = cnt_in;
         if (latch_rise) begin
            for (int k = 1; k <= NUM_CTRL; k++)
               if (cnt_in == CW'(k * BITS_PER_CTRL)) commit_ok = 1'b1;
            if (commit_ok) begin
               data_d = shift_in;
               fv_d   = 1'b1;
            end else begin
               fe_d   = 1'b1;
            end
            shift_d = ONES;
            cnt_d   = '0;
         end
         if (commit_ok) begin
            wd_d    = '0;
            stale_d = 1'b0;
         end else if (TIMEOUT_CYCLES > 0 && wd_q != WD_MAX) begin
            wd_d = wd_inc;
            if (wd_inc == WD_MAX) begin
               stale_d = 1'b1;
               data_d  = ONES;
            end
         end
      end
   end

   // Events only between controllers present in both the outgoing and incoming frame.
   always_comb begin
      set_p = '0;
      set_r = '0;
      old_f = '0;
      new_f = '0;
      if (commit_ok) begin
         for (int k = 0; k < NUM_CTRL; k++) begin
            old_f = data_q[k*BITS_PER_CTRL +: BITS_PER_CTRL];
            new_f = shift_in[k*BITS_PER_CTRL +: BITS_PER_CTRL];
            if (old_f != CTRL_ONES && new_f != CTRL_ONES) begin
               set_p[k*BITS_PER_CTRL +: BITS_PER_CTRL] = new_f & ~old_f;
               set_r[k*BITS_PER_CTRL +: BITS_PER_CTRL] = old_f & ~new_f;
            end
         end
      end
      pressed_d  = (pressed_q & ~evt_clr) | set_p;
      released_d = (released_q & ~evt_clr) | set_r;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shift_q    <= ONES;
         cnt_q      <= '0;
         data_q     <= ONES;
         wd_q       <= '0;
         stale_q    <= 1'b0;
         fv_q       <= 1'b0;
         fe_q       <= 1'b0;
         pressed_q  <= '0;
         released_q <= '0;
      end else begin
         shift_q    <= shift_d;
         cnt_q      <= cnt_d;
         data_q     <= data_d;
         wd_q       <= wd_d;
         stale_q    <= stale_d;
         fv_q       <= fv_d;
         fe_q       <= fe_d;
         pressed_q  <= pressed_d;
         released_q <= released_d;
      end
   end

   always_comb begin
      present = '0;
      for (int k = 0; k < NUM_CTRL; k++)
         present[k] = (data_q[k*BITS_PER_CTRL +: BITS_PER_CTRL] != CTRL_ONES);
   end

   assign data_out    = data_q;
   assign frame_valid = fv_q;
   assign frame_error = fe_q;
   assign stale       = stale_q;
   assign pressed     = pressed_q;
   assign released    = released_q;
   assign irq         = (|pressed_q) | (|released_q);

endmodule

// File: doc/gamepad_pmod_rx_multi.md
Name: gamepad_pmod_rx_multi

Overview:
- Parametrised successor to the single-pair Gamepad Pmod serial receiver. Handles N controllers of B bits each.
- Adds four functions:
  - frame-length validation;
  - per-controller presence;
  - sticky press/release event capture with write-one-to-clear;
  - a link watchdog that reverts outputs to "not present" when latches stop.
- Sits between the ui_in Pmod pins and a TinyQV peripheral register wrapper. The wrapper maps the outputs to registers and uses irq.

Parameters:
- NUM_CTRL, 2, number of controllers in a full frame (1..4).
- BITS_PER_CTRL, 12, bits per controller.
- SYNC_STAGES, 2, synchroniser depth for the three pins (>=2).
- TIMEOUT_CYCLES, 0, clk cycles without a valid frame before stale; 0 disables the watchdog.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  receiver enable.
- pmod_data  in  1  serial data pin (async).
- pmod_clk  in  1  serial clock pin (async).
- pmod_latch  in  1  latch pin (async).
- data_out  out  NUM_CTRL*BITS_PER_CTRL  last committed frame; controller k occupies bits [k*B+B-1 : k*B].
- present  out  NUM_CTRL  controller k field != all ones.
- frame_valid  out  1  one-cycle pulse when a frame commits.
- frame_error  out  1  one-cycle pulse when a frame is rejected.
- stale  out  1  watchdog has expired.
- pressed  out  N*B  sticky 0->1 transitions of data_out.
- released  out  N*B  sticky 1->0 transitions of data_out.
- evt_clr  in  N*B  write-one-to-clear for both pressed and released.
- irq  out  1  |pressed | |released.

Behaviour:
- Reset (rst=1 at a clk edge): all outputs are cleared or set as follows.
  - data_out, shift register and synchronisers go to all ones.
  - present=0, pressed=0, released=0, frame_valid=0, frame_error=0, stale=0.
  - bit count=0, watchdog count=0.
  - Reset mid-frame discards the partial frame.
- Each pin passes through a SYNC_STAGES flop chain. A previous-value flop follows each chain for edge detection.
- Shifting: on a synced pmod_clk rising edge with en=1:
  - shift_reg <= {shift_reg[N*B-2:0], data_sync};
  - bit count increments, saturating at N*B+1.
- Commit: on a synced pmod_latch rising edge with en=1.
  - The frame is valid when count is in {B, 2B, ..., N*B}.
  - Valid frame: data_out <= shift_reg and frame_valid pulses. A short frame leaves the upper controllers at all ones, so they read as not present.
  - Invalid frame (count 0, not a multiple of B, or > N*B): data_out is held and frame_error pulses.
  - In both cases the shift register reloads to all ones and count resets to 0.
- Same-cycle clk and latch edges: the clk edge's bit is included first, then the commit evaluates the updated count and shift value.
- Latency: data_out, present and frame_valid update SYNC_STAGES+1 cycles after the pin latch rise.
- Events: computed on valid commits only, and only for controllers present in both the old and new frame.
  - pressed |= new & ~old.
  - released |= old & ~new.
  - evt_clr clears bits; when set and clear hit the same bit in the same cycle, set wins.
- Watchdog (TIMEOUT_CYCLES > 0):
  - The counter increments every cycle with en=1 and resets on each valid commit.
  - When it reaches TIMEOUT_CYCLES: stale=1, data_out becomes all ones, present becomes 0, no events are generated, and the counter holds.
  - The next valid commit clears stale. Events are not generated for that commit, because the old frame is all ones.
- en=0:
  - pin edges are ignored;
  - shift register and count are held at reload values (all ones / 0);
  - data_out, events and watchdog are frozen;
  - the synchronisers keep running, so there is no spurious edge when en rises.

Decomposition:
- Shared package gamepad_pmod_pkg holds localparams FRAME_BITS = N*B, CNT_W = $clog2(N*B+2), and the all-ones constant.
- One natural sub-module: pmod_pin_sync, a parametrised SYNC_STAGES synchroniser plus rising-edge pulse, instantiated three times.

Test Plan:
- Full frame: N=2, B=12, shift 24 bits 0x00A_005 then latch → data_out=0x00A005, present=2'b11, one frame_valid pulse, latency SYNC_STAGES+1.
- Short frame: shift 12 bits 0x001, latch → data_out=0xFFF001, present=2'b01; pressed is 0 because the previous frame had ctrl0 absent.
- Invalid frame: 13 bits then latch → frame_error pulse, data_out unchanged. A following 25-bit frame is also rejected.
- Events: frame 0x000000 then 0x000003 → pressed=0x000003, irq=1. evt_clr=0x000001 → pressed=0x000002. A same-cycle set and clear of bit 1 leaves it set.
- Watchdog: TIMEOUT_CYCLES=100, one valid frame then idle → stale=1 at cycle 100 after the commit, data_out=0xFFFFFF. The next valid frame clears stale with no events.
- Reset and enable: rst asserted mid-frame after 10 bits, then a 24-bit frame → commit is valid. With en=0, latch edges produce no pulses.
